// File: rtl/ps2_key_sequencer_if.sv
// rtl/ps2_key_sequencer_if.sv - PS/2 byte stream, converter and character FIFO signal bundle
interface ps2_key_sequencer_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [7:0]    sc;
    logic          shift;
    logic          capslock;
    logic [7:0]    ascii;
    logic [7:0]    char_data;
    logic          char_valid;
    logic          char_ready;
    logic          overflow;
    logic [CW-1:0] fifo_count;

    modport slave (
        input  rx_data, rx_valid, ascii, char_ready,
        output sc, shift, capslock, char_data, char_valid, overflow, fifo_count
    );

    modport master (
        output rx_data, rx_valid, ascii, char_ready,
        input  sc, shift, capslock, char_data, char_valid, overflow, fifo_count
    );
endinterface

// File: rtl/ps2_key_sequencer.sv
// rtl/ps2_key_sequencer.sv - PS/2 scan-code sequencer feeding a small ASCII character FIFO
module ps2_key_sequencer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int PREFIX_TIMEOUT = 1000000
) (
    input logic                  clk,
    input logic                  reset,
    ps2_key_sequencer_if.slave   bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(PREFIX_TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_BRK, S_EXT, S_EXT_BRK, S_LOOKUP} state_t;

    state_t          state_q, state_d;
    logic [7:0]      sc_q, sc_d;
    logic            shl_q, shl_d, shr_q, shr_d;
    logic            caps_q, caps_d, held_q, held_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q;
    logic [7:0]      mem_q [FIFO_DEPTH];

    logic            push, pop, full, accept;
    logic [7:0]      push_data;

    function automatic logic is_ignored(input logic [7:0] b);
        return (b == 8'h00) || (b == 8'hAA) || (b == 8'hFA) || (b == 8'hFE) ||
               (b == 8'hFF) || (b == 8'hE1) || (b == 8'h11) || (b == 8'h14);
    endfunction

    always_comb begin
        state_d   = state_q;
        sc_d      = sc_q;
        shl_d     = shl_q;
        shr_d     = shr_q;
        caps_d    = caps_q;
        held_d    = held_q;
        tmo_d     = '0;
        push      = 1'b0;
        push_data = 8'h00;
        case (state_q)
            S_IDLE: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data == 8'hF0)      state_d = S_BRK;
                    else if (bus.rx_data == 8'hE0) state_d = S_EXT;
                    else if (bus.rx_data == 8'h12) shl_d = 1'b1;
                    else if (bus.rx_data == 8'h59) shr_d = 1'b1;
                    else if (bus.rx_data == 8'h58) begin
                        // Typematic repeats of capslock must not re-toggle
                        if (!held_q) begin
                            caps_d = ~caps_q;
                            held_d = 1'b1;
                        end
                    end else if (bus.rx_data == 8'h5A) begin
                        push      = 1'b1;
                        push_data = 8'h0D;
                    end else if (!is_ignored(bus.rx_data)) begin
                        sc_d    = bus.rx_data;
                        state_d = S_LOOKUP;
                    end
                end
            end
            S_BRK, S_EXT, S_EXT_BRK: begin
                if (bus.rx_valid) begin
                    state_d = S_IDLE;
                    if (state_q == S_BRK) begin
                        if (bus.rx_data == 8'h12) shl_d = 1'b0;
                        if (bus.rx_data == 8'h59) shr_d = 1'b0;
                        if (bus.rx_data == 8'h58) held_d = 1'b0;
                    end else if (state_q == S_EXT) begin
                        if (bus.rx_data == 8'hF0) state_d = S_EXT_BRK;
                        if (bus.rx_data == 8'h71) begin
                            push      = 1'b1;
                            push_data = 8'h7F;
                        end
                    end
                end else if (tmo_q == TW'(PREFIX_TIMEOUT - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_LOOKUP: begin
                push      = 1'b1;
                push_data = bus.ascii;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign full   = (count_q == CW'(FIFO_DEPTH));
    assign pop    = bus.char_ready && (count_q != '0);
    assign accept = push && (!full || pop);

    always_comb begin
        count_d = count_q;
        if (accept && !pop)      count_d = count_q + CW'(1);
        else if (!accept && pop) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            sc_q     <= 8'h00;
            shl_q    <= 1'b0;
            shr_q    <= 1'b0;
            caps_q   <= 1'b0;
            held_q   <= 1'b0;
            tmo_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sc_q     <= sc_d;
            shl_q    <= shl_d;
            shr_q    <= shr_d;
            caps_q   <= caps_d;
            held_q   <= held_d;
            tmo_q    <= tmo_d;
            count_q  <= count_d;
            ovf_q    <= push && full && !pop;
            if (accept) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)    rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem_q[wr_ptr_q] <= push_data;
    end

    assign bus.sc         = sc_q;
    assign bus.shift      = shl_q | shr_q;
    assign bus.capslock   = caps_q;
    assign bus.char_valid = (count_q != '0);
    assign bus.char_data  = (count_q != '0) ? mem_q[rd_ptr_q] : 8'h00;
    assign bus.overflow   = ovf_q;
    assign bus.fifo_count = count_q;
endmodule

// File: tb/tb_ps2_key_sequencer.sv
// tb/tb_ps2_key_sequencer.sv - directed and randomized checks of ps2_key_sequencer against a queue model
module tb_ps2_key_sequencer;
    localparam int D = 4;
    localparam int T = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rdy = 1'b1;
    int   vectors = 0;
    int   fails   = 0;

    always #5 clk = ~clk;

    ps2_key_sequencer_if #(.FIFO_DEPTH(D)) bus ();

    ps2_key_sequencer #(.FIFO_DEPTH(D), .PREFIX_TIMEOUT(T)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    function automatic logic [7:0] conv(input logic [7:0] s, input logic sh, input logic cp);
        logic [7:0] lc;
        case (s)
            8'h1C: lc = 8'h61;
            8'h32: lc = 8'h62;
            8'h21: lc = 8'h63;
            8'h23: lc = 8'h64;
            8'h24: lc = 8'h65;
            8'h15: lc = 8'h71;
            8'h2B: lc = 8'h66;
            default: lc = 8'h00;
        endcase
        if (lc != 8'h00) return (sh ^ cp) ? lc - 8'h20 : lc;
        if (s == 8'h16) return sh ? 8'h21 : 8'h31;
        return 8'h00;
    endfunction

    assign bus.ascii = conv(bus.sc, bus.shift, bus.capslock);

    // Model: key state as plain flags, pending prefix bytes, and a queue of characters
    logic [7:0] mq[$];
    logic       m_shl, m_shr, m_caps, m_held, m_pend, m_ovf;
    logic [7:0] m_pend_ch, m_sc;
    logic [7:0] m_prefix[$];
    int         m_age;

    function automatic logic ignored(input logic [7:0] b);
        return b inside {8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF, 8'hE1, 8'h11, 8'h14};
    endfunction

    task automatic model_byte(input logic [7:0] b, output logic push, output logic [7:0] ch);
        push = 1'b0;
        ch   = 8'h00;
        m_age = 0;
        if (m_prefix.size() == 0) begin
            if (b == 8'hF0 || b == 8'hE0) m_prefix.push_back(b);
            else if (b == 8'h12) m_shl = 1'b1;
            else if (b == 8'h59) m_shr = 1'b1;
            else if (b == 8'h58) begin
                if (!m_held) begin m_caps = ~m_caps; m_held = 1'b1; end
            end else if (b == 8'h5A) begin push = 1'b1; ch = 8'h0D; end
            else if (!ignored(b)) begin
                m_sc = b;
                m_pend = 1'b1;
                m_pend_ch = conv(b, m_shl | m_shr, m_caps);
            end
        end else if (m_prefix[0] == 8'hF0) begin
            if (b == 8'h12) m_shl = 1'b0;
            if (b == 8'h59) m_shr = 1'b0;
            if (b == 8'h58) m_held = 1'b0;
            m_prefix.delete();
        end else if (m_prefix.size() == 1) begin
            m_prefix.delete();
            if (b == 8'hF0) begin m_prefix.push_back(8'hE0); m_prefix.push_back(8'hF0); end
            else if (b == 8'h71) begin push = 1'b1; ch = 8'h7F; end
        end else begin
            m_prefix.delete();
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_prefix.delete();
        m_shl = 0; m_shr = 0; m_caps = 0; m_held = 0; m_pend = 0; m_ovf = 0;
        m_pend_ch = 0; m_sc = 0; m_age = 0;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("char_valid", 8'(bus.char_valid), 8'(mq.size() != 0));
        chk("char_data",  bus.char_data, (mq.size() != 0) ? mq[0] : 8'h00);
        chk("fifo_count", 8'(bus.fifo_count), 8'(mq.size()));
        chk("overflow",   8'(bus.overflow), 8'(m_ovf));
        chk("shift",      8'(bus.shift), 8'(m_shl | m_shr));
        chk("capslock",   8'(bus.capslock), 8'(m_caps));
        chk("sc",         bus.sc, m_sc);
    endtask

    task automatic step(input logic v, input logic [7:0] d);
        logic       do_push;
        logic [7:0] pch;
        logic       pop;
        bus.rx_valid   = v;
        bus.rx_data    = d;
        bus.char_ready = rdy;
        pop = (mq.size() != 0) && rdy;
        do_push = 1'b0;
        pch = 8'h00;
        if (m_pend) begin
            do_push = 1'b1;
            pch = m_pend_ch;
            m_pend = 1'b0;
        end else if (v) begin
            model_byte(d, do_push, pch);
        end else if (m_prefix.size() != 0) begin
            if (m_age == T - 1) m_prefix.delete();
            else m_age++;
        end
        m_ovf = 1'b0;
        if (pop) void'(mq.pop_front());
        if (do_push) begin
            if (mq.size() == D) m_ovf = 1'b1;
            else mq.push_back(pch);
        end
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data = 8'h00;
        bus.char_ready = rdy;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_all();
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        step(1'b1, b);
        repeat (gap) step(1'b0, 8'h00);
    endtask

    task automatic send_r(input logic [7:0] b);
        int gap;
        gap = $urandom_range(2, 6);
        rdy = 1'($urandom_range(0, 1));
        step(1'b1, b);
        for (int g = 0; g < gap; g++) begin
            rdy = 1'($urandom_range(0, 1));
            step(1'b0, 8'h00);
        end
    endtask

    initial begin
        logic [7:0] letters [7];
        letters = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h15, 8'h16};
        bus.rx_valid = 1'b0;
        bus.rx_data = 8'h00;
        bus.char_ready = 1'b1;
        model_reset();

        // Reset and single make
        do_reset();
        rdy = 1'b1;
        step(1'b1, 8'h1C);
        chk("t1_sc", bus.sc, 8'h1C);
        step(1'b0, 8'h00);
        chk("t1_char", bus.char_data, 8'h61);
        step(1'b0, 8'h00);
        chk("t1_count", 8'(bus.fifo_count), 8'h00);

        // Shift with both shift keys
        foreach (letters[i]) if (i < 2) begin
            logic [7:0] sk;
            sk = (i == 0) ? 8'h12 : 8'h59;
            send(sk, 3);
            chk("t2_shift_held", 8'(bus.shift), 8'h01);
            send(8'h1C, 3); send(8'hF0, 2); send(8'h1C, 3);
            send(8'hF0, 2); send(sk, 3); send(8'h1C, 3);
        end

        // Capslock toggles once per press
        send(8'h58, 3); send(8'h58, 3); send(8'hF0, 2); send(8'h58, 3);
        chk("t3_caps_on", 8'(bus.capslock), 8'h01);
        rdy = 1'b0;
        send(8'h15, 3);
        chk("t3_Q", bus.char_data, 8'h51);
        rdy = 1'b1;
        send(8'h58, 2); send(8'hF0, 2); send(8'h58, 2); send(8'h15, 3);
        chk("t3_caps_off", 8'(bus.capslock), 8'h00);

        // Extended, enter, prefix timeout
        rdy = 1'b0;
        send(8'hE0, 2); send(8'h71, 2);
        chk("t4_del", bus.char_data, 8'h7F);
        rdy = 1'b1;
        send(8'hE0, 2); send(8'h75, 3);
        chk("t4_e075_none", 8'(bus.fifo_count), 8'h00);
        send(8'h5A, 3);
        send(8'hF0, T - 1); send(8'h1C, 3);
        send(8'hF0, T);     send(8'h1C, 3);
        step(1'b1, 8'h1C); step(1'b1, 8'h32); repeat (3) step(1'b0, 8'h00);

        // Fill, overflow, simultaneous push and pop while full
        rdy = 1'b0;
        send(8'h1C, 2); send(8'h32, 2); send(8'h21, 2); send(8'h23, 2);
        chk("t5_full", 8'(bus.fifo_count), 8'h04);
        step(1'b1, 8'h24);
        step(1'b0, 8'h00);
        chk("t5_ovf", 8'(bus.overflow), 8'h01);
        step(1'b0, 8'h00);
        chk("t5_head", bus.char_data, 8'h61);
        step(1'b1, 8'h2B);
        rdy = 1'b1;
        step(1'b0, 8'h00);
        chk("t5_both_count", 8'(bus.fifo_count), 8'h04);
        chk("t5_both_ovf", 8'(bus.overflow), 8'h00);
        repeat (6) step(1'b0, 8'h00);

        // Reset mid-sequence
        send(8'h12, 2);
        step(1'b1, 8'hF0);
        do_reset();
        send(8'h1C, 1);
        chk("t6_after_reset", bus.char_data, 8'h61);
        repeat (2) step(1'b0, 8'h00);

        // Randomized key activity
        for (int n = 0; n < 300; n++) begin
            int r;
            r = $urandom_range(0, 11);
            case (r)
                0, 1, 2, 3: send_r(letters[$urandom_range(0, 6)]);
                4: send_r($urandom_range(0, 1) ? 8'h12 : 8'h59);
                5: begin send_r(8'hF0); send_r($urandom_range(0, 1) ? 8'h12 : 8'h59); end
                6: send_r(8'h58);
                7: begin send_r(8'hF0); send_r(8'h58); end
                8: send_r(8'h5A);
                9: begin send_r(8'hE0); send_r($urandom_range(0, 1) ? 8'h71 : 8'h75); end
                10: begin send_r(8'hE0); send_r(8'hF0); send_r(8'h71); end
                default: send_r($urandom_range(0, 1) ? 8'hAA : 8'h11);
            endcase
            if (n % 97 == 96) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
